// File: rtl/etapa_busqueda_pkg.sv
// Shared constants for the instruction-fetch stage and the control unit it feeds.
// State encodings, the J-type opcode and the jump-target helper live here.
package etapa_busqueda_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [5:0]  OP_J   = 6'b000010;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    // Pseudo-direct J-type target: upper nibble of pc+4, 26-bit index, word offset.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/etapa_busqueda_if_id.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and a missing
// load while not held inserts a bubble that keeps the old instr/pc4 bits.
module registro_if_id (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!hold) begin
            valid_d = load;
            if (load) begin
                instr_d = instr_in;
                pc4_d   = pc4_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, skid buffer
// for decode stalls, and branch/jump redirect with wrong-path flush.
module etapa_busqueda
    import etapa_busqueda_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    output logic [XLEN-1:0] pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [5:0]      op
);

    logic [1:0]   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         skid_valid_q, skid_valid_d;
    fetch_entry_t skid_q, skid_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         if_load;
    fetch_entry_t if_entry;

    assign redirect = branch_taken | (jump & if_id_valid);
    // The branch is the older instruction, so it takes priority over the jump.
    assign target   = branch_taken ? branch_target : jump_target(if_id_pc4, if_id_instr);
    assign pc_plus4 = pc_q + PC_INC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if_load      = 1'b0;
        if_entry     = '{instr: imem_rdata, pc4: pc_plus4};
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                pc_d    = redirect ? target : pc_q;
                addr_d  = pc_d;
            end
            ST_REQ: begin
                if (!imem_ready) begin
                    if (redirect) begin
                        pc_d    = target;
                        state_d = ST_DRAIN;
                    end
                end else if (redirect) begin
                    pc_d   = target;
                    addr_d = target;
                end else if (!stall) begin
                    if_load = 1'b1;
                    pc_d    = pc_plus4;
                    addr_d  = pc_plus4;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_d       = '{instr: imem_rdata, pc4: pc_plus4};
                    pc_d         = pc_plus4;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    skid_valid_d = 1'b0;
                    pc_d         = target;
                    addr_d       = target;
                    state_d      = ST_REQ;
                end else if (!stall) begin
                    if_load      = skid_valid_q;
                    if_entry     = skid_q;
                    skid_valid_d = 1'b0;
                    addr_d       = pc_q;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                // Stale word still in flight: keep the old address until it lands.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    addr_d  = pc_d;
                    state_d = ST_REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    registro_if_id u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (if_load),
        .flush    (redirect),
        .hold     (stall),
        .instr_in (if_entry.instr),
        .pc4_in   (if_entry.pc4),
        .valid    (if_id_valid),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4)
    );

    assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign imem_addr = addr_q;
    assign pc        = pc_q;
    assign op        = if_id_instr[31:26];

endmodule

// File: tb/tb_etapa_busqueda.sv
// Scoreboarded bench for etapa_busqueda: directed scenarios push expected IF/ID
// entries, a monitor pops them each time decode consumes a live instruction.
module tb_etapa_busqueda;
    import etapa_busqueda_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_entry_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  op;

    logic        jump_en;
    logic [31:0] jump_addr;
    int          mem_latency;
    int          wait_cnt;
    int          tests_run;
    int          tests_failed;
    exp_entry_t  exp_q[$];

    etapa_busqueda dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .pc            (pc),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .op            (op)
    );

    // Stand-in for the control unit's Jump decode.
    assign jump = jump_en && (op == OP_J);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == jump_addr) return 32'h0800_0010;
        return a | 32'h2000_0000;
    endfunction

    // Memory answers after mem_latency wait cycles of a held request.
    always @(posedge clk) begin
        #1;
        if (rst || !imem_req) begin
            imem_ready = 1'b0;
            wait_cnt   = 0;
        end else if (wait_cnt >= mem_latency) begin
            imem_ready = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wait_cnt   = 0;
        end else begin
            imem_ready = 1'b0;
            wait_cnt   = wait_cnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
        exp_entry_t e;
        e.instr = instr;
        e.pc4   = pc4;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic stall_v, input logic br_v, input logic [31:0] tgt_v);
        stall         = stall_v;
        branch_taken  = br_v;
        branch_target = tgt_v;
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        jump_en     = 1'b0;
        mem_latency = 0;
        jump_addr   = 32'hFFFF_FFFF;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        check_output("sb_drained", exp_q.size(), 0);
        rst = 1'b0;
    endtask

    // Decode consumes IF/ID whenever it is live, not stalled and not being squashed by a branch.
    initial begin
        exp_entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && if_id_valid && !stall && !branch_taken) begin
                if (exp_q.size() == 0) begin
                    tests_run    = tests_run + 1;
                    tests_failed = tests_failed + 1;
                    $display("[TB] FAIL sb_unexpected: got instr %h pc4 %h, expected nothing", if_id_instr, if_id_pc4);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_instr", if_id_instr, e.instr);
                    check_output("sb_pc4", if_id_pc4, e.pc4);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        wait_cnt     = 0;
        rst          = 1'b1;
        jump_en      = 1'b0;
        mem_latency  = 0;
        jump_addr    = 32'hFFFF_FFFF;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        check_output("rst_pc", pc, 32'h0);
        check_output("rst_req", {31'b0, imem_req}, 32'h0);
        check_output("rst_addr", imem_addr, 32'h0);
        check_output("rst_valid", {31'b0, if_id_valid}, 32'h0);
        check_output("rst_instr", if_id_instr, 32'h0);
        check_output("rst_pc4", if_id_pc4, 32'h0);
        check_output("rst_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});

        // Back-to-back fetch, then a 3-cycle stall that forces the skid path.
        push_exp(32'h2000_0000, 32'h4);
        push_exp(32'h2000_0004, 32'h8);
        push_exp(32'h2000_0008, 32'hC);
        push_exp(32'h2000_000C, 32'h10);
        push_exp(32'h2000_0010, 32'h14);
        rst = 1'b0;
        @(negedge clk);
        check_output("seq_addr0", imem_addr, 32'h0);
        check_output("seq_req", {31'b0, imem_req}, 32'h1);
        check_output("seq_valid0", {31'b0, if_id_valid}, 32'h0);
        @(negedge clk);
        check_output("seq_addr4", imem_addr, 32'h4);
        check_output("seq_valid1", {31'b0, if_id_valid}, 32'h1);
        check_output("seq_pc4_4", if_id_pc4, 32'h4);
        @(negedge clk);
        check_output("seq_addr8", imem_addr, 32'h8);
        check_output("seq_pc4_8", if_id_pc4, 32'h8);
        @(negedge clk);
        check_output("seq_pc4_12", if_id_pc4, 32'hC);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_output("stall_state", {30'b0, dut.state_q}, {30'b0, ST_HOLD});
        check_output("stall_req", {31'b0, imem_req}, 32'h0);
        check_output("stall_pc4", if_id_pc4, 32'hC);
        repeat (2) @(negedge clk);
        check_output("stall_hold_pc4", if_id_pc4, 32'hC);
        check_output("stall_hold_state", {30'b0, dut.state_q}, {30'b0, ST_HOLD});
        apply_stimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_output("skid_pc4", if_id_pc4, 32'h10);
        check_output("skid_addr", imem_addr, 32'h10);
        check_output("skid_state", {30'b0, dut.state_q}, {30'b0, ST_REQ});
        @(negedge clk);
        check_output("after_skid_pc4", if_id_pc4, 32'h14);
        @(negedge clk);
        reset_dut();

        // Jump held in IF/ID at address 4 targets 0x40.
        jump_addr = 32'h4;
        jump_en   = 1'b1;
        push_exp(32'h2000_0000, 32'h4);
        push_exp(32'h0800_0010, 32'h8);
        push_exp(32'h2000_0040, 32'h44);
        repeat (3) @(negedge clk);
        check_output("jmp_op", {26'b0, op}, {26'b0, OP_J});
        @(negedge clk);
        check_output("jmp_addr", imem_addr, 32'h40);
        check_output("jmp_flush", {31'b0, if_id_valid}, 32'h0);
        @(negedge clk);
        check_output("jmp_valid", {31'b0, if_id_valid}, 32'h1);
        check_output("jmp_pc4", if_id_pc4, 32'h44);
        @(negedge clk);
        reset_dut();

        // Branch while a slow request is outstanding: drain the stale word.
        mem_latency = 3;
        push_exp(32'h2000_0100, 32'h104);
        repeat (2) @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 32'h100);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("drain_state", {30'b0, dut.state_q}, {30'b0, ST_DRAIN});
        check_output("drain_req", {31'b0, imem_req}, 32'h1);
        check_output("drain_addr", imem_addr, 32'h0);
        check_output("drain_pc", pc, 32'h100);
        @(negedge clk);
        check_output("drain_state2", {30'b0, dut.state_q}, {30'b0, ST_DRAIN});
        @(negedge clk);
        check_output("drain_exit_state", {30'b0, dut.state_q}, {30'b0, ST_REQ});
        check_output("drain_new_addr", imem_addr, 32'h100);
        check_output("drain_no_stale", {31'b0, if_id_valid}, 32'h0);
        for (int i = 0; i < 12 && !if_id_valid; i++) @(negedge clk);
        check_output("drain_capture", {31'b0, if_id_valid}, 32'h1);
        check_output("drain_pc4", if_id_pc4, 32'h104);
        @(negedge clk);
        reset_dut();

        // Branch and jump in the same cycle: branch wins.
        jump_addr = 32'h4;
        jump_en   = 1'b1;
        push_exp(32'h2000_0000, 32'h4);
        push_exp(32'h2000_0200, 32'h204);
        repeat (3) @(negedge clk);
        check_output("both_op", {26'b0, op}, {26'b0, OP_J});
        apply_stimulus(1'b0, 1'b1, 32'h200);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("both_addr", imem_addr, 32'h200);
        check_output("both_flush", {31'b0, if_id_valid}, 32'h0);
        @(negedge clk);
        check_output("both_pc4", if_id_pc4, 32'h204);
        @(negedge clk);
        reset_dut();

        // PC wrap at the top of the address space, then reset mid-request.
        push_exp(32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check_output("wrap_addr0", imem_addr, 32'h0);
        check_output("wrap_pc", pc, 32'h0);
        check_output("wrap_pc4", if_id_pc4, 32'h0);
        check_output("wrap_instr", if_id_instr, 32'hFFFF_FFFC);
        @(negedge clk);
        check_output("mid_req", {31'b0, imem_req}, 32'h1);
        check_output("mid_addr", imem_addr, 32'h4);
        rst = 1'b1;
        @(negedge clk);
        check_output("mid_rst_pc", pc, 32'h0);
        check_output("mid_rst_req", {31'b0, imem_req}, 32'h0);
        check_output("mid_rst_addr", imem_addr, 32'h0);
        check_output("mid_rst_valid", {31'b0, if_id_valid}, 32'h0);
        check_output("mid_rst_instr", if_id_instr, 32'h0);
        check_output("mid_rst_pc4", if_id_pc4, 32'h0);
        check_output("mid_rst_op", {26'b0, op}, 32'h0);
        check_output("mid_rst_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
        @(negedge clk);
        check_output("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
